fifo_burst_reader: RTL and testbench

Read-side controller for the team's synchronous FIFO. It watches the FIFO fill level, drains words in bursts of up to `BURST_LEN`, absorbs the FIFO's one-cycle read latency in a 2-entry output buffer, and presents the words on a valid/ready stream with an end-of-burst marker. It sits between the FIFO read port and any downstream consumer, such as a packet framer, a UART TX or a bus master.

---
 rtl/fifo_burst_reader.sv | 139 +++++++++++++
 tb/tb_fifo_burst_reader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader.sv
// Read-side burst controller for the synchronous FIFO: drains bursts of up to BURST_LEN
// words onto a valid/ready stream. Define FIFO_BURST_READER_TIMEOUT_EN to flush partial bursts.
module fifo_burst_reader #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int BURST_LEN = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic                  fifo_full,
    input  logic [(DEPTH>>1)-1:0] fifo_usedw,
    input  logic [WIDTH-1:0]      fifo_q,
    output logic                  fifo_rd,
    output logic [WIDTH-1:0]      m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  busy
);
    localparam int CW = $clog2(DEPTH) + 1;

    if (BURST_LEN < 1 || BURST_LEN > DEPTH || TIMEOUT < 1) begin : g_bad_param
        $error("fifo_burst_reader: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, BURST, FLUSH} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   rd_left, tx_left, avail, start_len;
    logic [1:0]      occ;
    logic            inflight, pop, start;
    logic [WIDTH-1:0] buf0, buf1;

    // usedw cannot represent a full FIFO, so the full flag supplies DEPTH
    assign avail   = fifo_full ? CW'(DEPTH) : CW'(fifo_usedw);
    assign m_valid = (occ != 2'd0);
    assign pop     = m_valid && m_ready;
    assign m_data  = buf0;
    assign m_last  = m_valid && (tx_left == CW'(1));
    assign busy    = (state != IDLE);

    // Reads already in flight reserve a buffer slot; a pop this cycle frees one
    assign fifo_rd = (state == BURST) && !fifo_empty && (rd_left != '0) &&
                     (({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));

`ifdef FIFO_BURST_READER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] idle_cnt;
    logic          idle_cond, to_hit;

    assign idle_cond = (state == IDLE) && !fifo_empty && (avail < CW'(BURST_LEN));
    assign to_hit    = idle_cond && (idle_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (idle_cond && !to_hit) begin
            idle_cnt <= idle_cnt + TW'(1);
        end else begin
            idle_cnt <= '0;
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        start_len = CW'(BURST_LEN);
        case (state)
            IDLE: begin
                if (avail >= CW'(BURST_LEN)) begin
                    start = 1'b1;
                end
`ifdef FIFO_BURST_READER_TIMEOUT_EN
                else if (to_hit) begin
                    start     = 1'b1;
                    start_len = avail;
                end
`endif
                if (start) state_nxt = BURST;
            end
            BURST: if (rd_left == '0) state_nxt = FLUSH;
            FLUSH: if (pop && m_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rd_left  <= '0;
            tx_left  <= '0;
            inflight <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= fifo_rd;
            if (start) begin
                rd_left <= start_len;
                tx_left <= start_len;
            end else begin
                if (fifo_rd) rd_left <= rd_left - CW'(1);
                if (pop)     tx_left <= tx_left - CW'(1);
            end
        end
    end

    // Two-entry skid buffer: buf0 is the head and drives m_data directly
    always_ff @(posedge clk) begin
        if (rst) begin
            occ  <= 2'd0;
            buf0 <= '0;
            buf1 <= '0;
        end else begin
            case ({inflight, pop})
                2'b10: begin
                    if (occ == 2'd0) buf0 <= fifo_q;
                    else             buf1 <= fifo_q;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    buf0 <= buf1;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        buf0 <= fifo_q;
                    end else begin
                        buf0 <= buf1;
                        buf1 <= fifo_q;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a behavioural depth-4 FIFO feeding it.
module tb_fifo_burst_reader;
    localparam int WIDTH = 8, DEPTH = 4, BURST_LEN = 4, TIMEOUT = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             fifo_empty, fifo_full, fifo_rd;
    logic [1:0]       fifo_usedw;
    logic [WIDTH-1:0] fifo_q, m_data;
    logic             m_valid, m_ready, m_last, busy;

    int errors = 0;
    int checks = 0;

    logic [7:0] src[$];
    logic [7:0] mem[4];
    logic [1:0] rp, wp;
    logic [2:0] cnt;
    logic       rd_ok;

    always #5 clk = ~clk;

    fifo_burst_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BURST_LEN(BURST_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
        .fifo_usedw(fifo_usedw), .fifo_q(fifo_q), .fifo_rd(fifo_rd), .m_data(m_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .busy(busy)
    );

    assign fifo_empty = (cnt == 3'd0);
    assign fifo_full  = (cnt == 3'd4);
    assign fifo_usedw = cnt[1:0];
    assign rd_ok      = fifo_rd && !fifo_empty;

    // FIFO model: one-cycle read latency, writer pushes from src whenever there is room
    always @(posedge clk) begin
        if (rst) begin
            cnt <= 3'd0; rp <= 2'd0; wp <= 2'd0; fifo_q <= 8'h00;
        end else begin
            if (rd_ok) begin
                fifo_q <= mem[rp];
                rp <= rp + 2'd1;
            end
            if (src.size() != 0 && cnt != 3'd4) begin
                mem[wp] <= src.pop_front();
                wp <= wp + 2'd1;
                if (!rd_ok) cnt <= cnt + 3'd1;
            end else if (rd_ok) begin
                cnt <= cnt - 3'd1;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1; m_ready = 1'b0; src.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; m_ready = 1'b1; src.delete();
        repeat (2) @(negedge clk);
        #1;
        checks++; if (fifo_rd !== 1'b0) begin errors++; $display("FAIL reset_fifo_rd got=%b exp=0", fifo_rd); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
        checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last got=%b exp=0", m_last); end
        checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL reset_m_data got=%h exp=00", m_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst = 1'b0;
    endtask

    task automatic test_single_burst();
        logic [7:0] exp_d[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [7:0] got_d[4] = '{default: 8'h00};
        logic       got_l[4] = '{default: 1'b0};
        int         got_c[4] = '{default: 0};
        int         n = 0, first_rd = -1, first_vld = -1;
        logic       busy_at_rd = 1'b0;
        do_reset();
        m_ready = 1'b1;
        foreach (exp_d[i]) src.push_back(exp_d[i]);
        for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
            @(negedge clk); #1;
            if (fifo_rd && first_rd < 0) begin first_rd = cyc; busy_at_rd = busy; end
            if (m_valid && first_vld < 0) first_vld = cyc;
            if (m_valid && m_ready) begin
                got_d[n] = m_data; got_l[n] = m_last; got_c[n] = cyc; n++;
            end
        end
        @(negedge clk); #1;
        checks++; if (n != 4) begin errors++; $display("FAIL single_count got=%0d exp=4", n); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (got_d[i] !== exp_d[i]) begin errors++; $display("FAIL single_data[%0d] got=%h exp=%h", i, got_d[i], exp_d[i]); end
            checks++; if (got_l[i] !== (i == 3)) begin errors++; $display("FAIL single_last[%0d] got=%b exp=%b", i, got_l[i], (i == 3)); end
        end
        checks++; if (got_c[3] - got_c[0] != 3) begin errors++; $display("FAIL single_back_to_back span got=%0d exp=3", got_c[3] - got_c[0]); end
        checks++; if (first_vld - first_rd != 2) begin errors++; $display("FAIL single_latency got=%0d exp=2", first_vld - first_rd); end
        checks++; if (busy_at_rd !== 1'b1) begin errors++; $display("FAIL single_busy_at_rd got=%b exp=1", busy_at_rd); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after got=%b exp=0", busy); end
    endtask

    task automatic test_two_bursts();
        logic [7:0] got_d[8] = '{default: 8'h00};
        logic       got_l[8] = '{default: 1'b0};
        int         n = 0, rd_empty = 0;
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) src.push_back(8'(8'h80 + i));
        for (int cyc = 0; cyc < 80 && n < 8; cyc++) begin
            @(negedge clk); #1;
            if (fifo_rd && fifo_empty) rd_empty++;
            if (m_valid && m_ready) begin got_d[n] = m_data; got_l[n] = m_last; n++; end
        end
        checks++; if (n != 8) begin errors++; $display("FAIL two_count got=%0d exp=8", n); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (got_d[i] !== 8'(8'h80 + i)) begin errors++; $display("FAIL two_data[%0d] got=%h exp=%h", i, got_d[i], 8'(8'h80 + i)); end
            checks++; if (got_l[i] !== (i == 3 || i == 7)) begin errors++; $display("FAIL two_last[%0d] got=%b exp=%b", i, got_l[i], (i == 3 || i == 7)); end
        end
        checks++; if (rd_empty != 0) begin errors++; $display("FAIL two_rd_while_empty got=%0d exp=0", rd_empty); end
    endtask

    task automatic test_backpressure();
        logic [7:0] got_d[4] = '{default: 8'h00};
        logic       got_l[4] = '{default: 1'b0};
        int         n = 0, rd_cnt = 0, vld_cyc = 0, unstable = 0, last_hi = 0;
        logic       resume_rd = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) src.push_back(8'(8'h51 + i));
        for (int cyc = 0; cyc < 25; cyc++) begin
            @(negedge clk); m_ready = 1'b0; #1;
            if (fifo_rd) rd_cnt++;
            if (m_valid) begin
                vld_cyc++;
                if (m_data !== 8'h51) unstable++;
                if (m_last) last_hi++;
            end
        end
        checks++; if (rd_cnt != 2) begin errors++; $display("FAIL bp_reads got=%0d exp=2", rd_cnt); end
        checks++; if (vld_cyc < 10) begin errors++; $display("FAIL bp_valid_cycles got=%0d exp>=10", vld_cyc); end
        checks++; if (unstable != 0) begin errors++; $display("FAIL bp_data_stable bad_cycles=%0d exp=0", unstable); end
        checks++; if (last_hi != 0) begin errors++; $display("FAIL bp_last_early got=%0d exp=0", last_hi); end
        for (int cyc = 0; cyc < 20 && n < 4; cyc++) begin
            @(negedge clk); m_ready = 1'b1; #1;
            if (cyc == 0) resume_rd = fifo_rd;
            if (m_valid && m_ready) begin got_d[n] = m_data; got_l[n] = m_last; n++; end
        end
        checks++; if (resume_rd !== 1'b1) begin errors++; $display("FAIL bp_resume_rd got=%b exp=1", resume_rd); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (got_d[i] !== 8'(8'h51 + i)) begin errors++; $display("FAIL bp_data[%0d] got=%h exp=%h", i, got_d[i], 8'(8'h51 + i)); end
            checks++; if (got_l[i] !== (i == 3)) begin errors++; $display("FAIL bp_last[%0d] got=%b exp=%b", i, got_l[i], (i == 3)); end
        end
    endtask

    task automatic test_timeout();
        int n = 0, first_vld = -1, vld_cnt = 0, rd_cnt = 0, busy_cnt = 0;
        logic [7:0] got_d[2] = '{default: 8'h00};
        logic       got_l[2] = '{default: 1'b0};
        do_reset();
        m_ready = 1'b1;
        src.push_back(8'hA0); src.push_back(8'hA1);
`ifdef FIFO_BURST_READER_TIMEOUT_EN
        for (int cyc = 0; cyc < 60 && n < 2; cyc++) begin
            @(negedge clk); #1;
            if (m_valid && first_vld < 0) first_vld = cyc;
            if (m_valid && m_ready) begin got_d[n] = m_data; got_l[n] = m_last; n++; end
        end
        @(negedge clk); #1;
        checks++; if (first_vld != 18) begin errors++; $display("FAIL timeout_first_valid cycle got=%0d exp=18", first_vld); end
        checks++; if (n != 2) begin errors++; $display("FAIL timeout_count got=%0d exp=2", n); end
        checks++; if (got_d[0] !== 8'hA0 || got_d[1] !== 8'hA1) begin errors++; $display("FAIL timeout_data got=%h,%h exp=a0,a1", got_d[0], got_d[1]); end
        checks++; if (got_l[0] !== 1'b0 || got_l[1] !== 1'b1) begin errors++; $display("FAIL timeout_last got=%b,%b exp=0,1", got_l[0], got_l[1]); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy_after got=%b exp=0", busy); end
`else
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge clk); #1;
            if (m_valid) vld_cnt++;
            if (fifo_rd) rd_cnt++;
            if (busy) busy_cnt++;
        end
        checks++; if (vld_cnt != 0) begin errors++; $display("FAIL notimeout_valid got=%0d exp=0", vld_cnt); end
        checks++; if (rd_cnt != 0) begin errors++; $display("FAIL notimeout_reads got=%0d exp=0", rd_cnt); end
        checks++; if (busy_cnt != 0) begin errors++; $display("FAIL notimeout_busy got=%0d exp=0", busy_cnt); end
`endif
    endtask

    task automatic test_reset_mid();
        int n = 0;
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) src.push_back(8'(8'h61 + i));
        for (int cyc = 0; cyc < 40 && n < 2; cyc++) begin
            @(negedge clk); #1;
            if (m_valid && m_ready) n++;
        end
        @(negedge clk); rst = 1'b1;
        @(negedge clk); src.delete(); rst = 1'b0; #1;
        checks++; if (n != 2) begin errors++; $display("FAIL midrst_accepted got=%0d exp=2", n); end
        checks++; if (fifo_rd !== 1'b0) begin errors++; $display("FAIL midrst_fifo_rd got=%b exp=0", fifo_rd); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL midrst_m_valid got=%b exp=0", m_valid); end
        checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL midrst_m_last got=%b exp=0", m_last); end
        checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL midrst_m_data got=%h exp=00", m_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        @(negedge clk); #1;
        checks++; if (busy !== 1'b0 || m_valid !== 1'b0) begin errors++; $display("FAIL midrst_stays_idle busy=%b valid=%b exp=0,0", busy, m_valid); end
    endtask

    task automatic test_random();
        int         n = 0, unstable = 0, rd_empty = 0;
        logic       prev_stall = 1'b0, prev_last = 1'b0;
        logic [7:0] prev_data = 8'h00, e;
        do_reset();
        for (int i = 0; i < 1000; i++) src.push_back(8'(i * 7 + 3));
        for (int cyc = 0; cyc < 20000 && n < 1000; cyc++) begin
            @(negedge clk); m_ready = 1'($urandom_range(0, 1)); #1;
            if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last)) unstable++;
            if (fifo_rd && fifo_empty) rd_empty++;
            if (m_valid && m_ready) begin
                e = 8'(n * 7 + 3);
                checks++; if (m_data !== e) begin errors++; $display("FAIL rand_data[%0d] got=%h exp=%h", n, m_data, e); end
                checks++; if (m_last !== (n % 4 == 3)) begin errors++; $display("FAIL rand_last[%0d] got=%b exp=%b", n, m_last, (n % 4 == 3)); end
                n++;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
        checks++; if (n != 1000) begin errors++; $display("FAIL rand_count got=%0d exp=1000", n); end
        checks++; if (unstable != 0) begin errors++; $display("FAIL rand_stall_stable bad=%0d exp=0", unstable); end
        checks++; if (rd_empty != 0) begin errors++; $display("FAIL rand_rd_while_empty got=%0d exp=0", rd_empty); end
    endtask

    initial begin
        m_ready = 1'b0;
        test_reset();
        test_single_burst();
        test_two_bursts();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
